matrix_loader: RTL
==================

# matrix_loader

Upstream stage of the SIMD matrix core. It accepts a 32-bit element stream holding operand matrix A then B, row-major. It packs four consecutive elements into one 128-bit RAM word and writes them into the core's A and B operand RAMs. It then issues the one-cycle start pulse to the core and waits for its stop indication before accepting the next operand pair.

## Interface
Parameters:
- ELEM_W, 32, element width in bits
- LANES, 4, elements per RAM word
- ROWS, 8, matrix rows
- COLS, 8, matrix columns
- ADDR_W, 4, RAM address width; words per matrix WPM = ROWS*COLS/LANES = 16

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_data  in  ELEM_W  stream element
- s_valid  in  1  element present
- s_ready  out  1  loader accepts element; a beat transfers when s_valid && s_ready
- s_last  in  1  marks final element of each matrix
- wr_en_a  out  1  write strobe, A RAM
- wr_en_b  out  1  write strobe, B RAM
- wr_addr  out  ADDR_W  RAM word address
- wr_data  out  LANES*ELEM_W  packed word; element k of the group at bits [k*ELEM_W +: ELEM_W]
- core_valid  out  1  start pulse to the core
- core_stop  in  1  core done level
- busy  out  1  high in any state other than LOAD_A with zero beats taken
- err_last  out  1  sticky framing error

## Operation
- FSM states: LOAD_A → LOAD_B → START → WAIT → LOAD_A.
- LOAD_A and LOAD_B: s_ready=1; in START and WAIT, s_ready=0.
- Beat counter runs 0..ROWS*COLS-1 per matrix. Every LANES-th accepted beat completes a word, written to address = word index (0..WPM-1).
- LOAD_A moves to LOAD_B on the edge accepting beat 63. LOAD_B moves to START on the edge accepting beat 63.
- START is one cycle with core_valid=1, then WAIT.
- WAIT: exit to LOAD_A on a rising edge of core_stop (core_stop=1 while the prior-cycle sample stop_q=0). A core_stop level that is already high on entry is ignored until it falls and rises again.
- Framing is positional. An s_last value that disagrees with "beat == 63" sets err_last; the beat is still accepted normally. err_last is cleared only by rst.
- No stall from the RAM side; writes always succeed.

## Timing
- Reset values: s_ready=0 during rst, and 1 from the first cycle after rst deasserts (LOAD_A). All other outputs are 0: wr_en_a, wr_en_b, wr_addr, wr_data, core_valid, busy, err_last. State is LOAD_A, counters are 0, stop_q=0.
- Write latency: wr_en_*, wr_addr and wr_data are registered. They are high for exactly one cycle, the cycle after the edge that accepted the word's 4th beat.
- core_valid is high in the cycle after the write of B word 15, i.e. two cycles after the final beat's accepting edge.
- Minimum WAIT duration: 1 cycle. s_ready returns on the cycle after the edge on which the stop rising edge is sampled.
- rst mid-operation: the partial word is discarded with no write, counters and state are cleared, and no core_valid is issued.
- Gaps in s_valid stall only the counters; partial-word contents are held.

## Structure
- Package simd_pkg holds:
  - ELEM_W, LANES and WPM constants
  - typedef word_t of LANES*ELEM_W bits
  - enum ld_state_t {LOAD_A, LOAD_B, START, WAIT}
- Sub-module lane_packer:
  - LANES-deep element register plus lane index
  - outputs word_t and word_done
  - cleared by rst
- Top level holds the FSM, beat/word counters, stop edge detect and err_last.

## Test plan
- Reset then zero-gap stream, A elem=i and B elem=100+i:
  - 16 wr_en_a writes at addr 0..15; addr 0 data = {32'd3,32'd2,32'd1,32'd0}
  - 16 wr_en_b writes; addr 15 data = {32'd163,32'd162,32'd161,32'd160}
  - one core_valid pulse two cycles after the last beat
- Same data with random s_valid gaps (~50%) → identical write sequence and data; s_ready stays 1 throughout loading.
- s_last asserted at beat 10 of A and dropped at beat 63 → err_last=1 from the cycle after beat 10, all 32 writes still correct, err_last held until rst.
- core_stop held high entering WAIT → s_ready stays 0. core_stop low for 3 cycles then high → s_ready=1 two cycles after the rise.
- rst pulse after 6 beats of A → no further writes, all outputs 0. A fresh stream then writes from addr 0 with correct data.
- Two consecutive full runs, each with a core_stop rising edge → two core_valid pulses, 64 total writes, no err_last.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared types for the SIMD matrix core front end.
// Element/word geometry and loader FSM states.
package simd_pkg;

  localparam int ELEM_W = 32;
  localparam int LANES  = 4;
  localparam int WPM    = 16;
  localparam int LANE_IW = $clog2(LANES);

  typedef logic [LANES*ELEM_W-1:0] word_t;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT
  } ld_state_t;

endpackage

// File: rtl/lane_packer.sv
// Packs LANES consecutive elements into one RAM word.
// The newest element is passed straight through as the top lane.
module lane_packer
  import simd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  output word_t             word,
  output logic              word_done
);

  localparam int SH_W = (LANES-1)*ELEM_W;

  logic [SH_W-1:0]    sh_q;
  logic [LANE_IW-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (in_valid) begin
      sh_q  <= {in_data, sh_q[SH_W-1:ELEM_W]};
      idx_q <= idx_q + 1'b1;
    end
  end

  assign word      = {in_data, sh_q};
  assign word_done = in_valid &&
                     (idx_q == LANE_IW'(LANES-1));

endmodule

// File: rtl/matrix_loader.sv
// Loads operand matrices A then B into the core RAMs,
// pulses the core start and waits for its stop edge.
module matrix_loader #(
  parameter int ELEM_W = 32,
  parameter int LANES  = 4,
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ELEM_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  output logic                    wr_en_a,
  output logic                    wr_en_b,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [LANES*ELEM_W-1:0] wr_data,
  output logic                    core_valid,
  input  logic                    core_stop,
  output logic                    busy,
  output logic                    err_last
);

  import simd_pkg::*;

  localparam int BEATS = ROWS*COLS;
  localparam int BW    = $clog2(BEATS);
  localparam int SH    = $clog2(LANES);

  ld_state_t state_q, state_d;

  logic [BW-1:0]           beat_q;
  logic                    stop_q;
  logic                    accept;
  logic                    last_beat;
  logic                    stop_rise;
  logic                    loading;
  logic [LANES*ELEM_W-1:0] word;
  logic                    word_done;

  assign loading   = (state_q == LOAD_A) ||
                     (state_q == LOAD_B);
  assign s_ready   = !rst && loading;
  assign accept    = s_valid && s_ready;
  assign last_beat = beat_q == BW'(BEATS-1);
  assign stop_rise = core_stop && !stop_q;
  assign busy      = !rst &&
                     !((state_q == LOAD_A) &&
                       (beat_q == '0));

  lane_packer u_pack (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_data   (s_data),
    .word      (word),
    .word_done (word_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD_A:
        if (accept && last_beat)
          state_d = LOAD_B;
      LOAD_B:
        if (accept && last_beat)
          state_d = START;
      START:
        state_d = WAIT;
      WAIT:
        if (stop_rise)
          state_d = LOAD_A;
      default:
        state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_A;
      beat_q     <= '0;
      stop_q     <= 1'b0;
      err_last   <= 1'b0;
      wr_en_a    <= 1'b0;
      wr_en_b    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      stop_q     <= core_stop;
      core_valid <= state_q == START;
      wr_en_a    <= word_done &&
                    (state_q == LOAD_A);
      wr_en_b    <= word_done &&
                    (state_q == LOAD_B);
      if (accept) begin
        beat_q <= beat_q + 1'b1;
        // framing is positional; s_last only flags
        if (s_last != last_beat)
          err_last <= 1'b1;
      end
      if (word_done) begin
        wr_addr <= ADDR_W'(beat_q >> SH);
        wr_data <= word;
      end
    end
  end

endmodule
